display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_if.sv | 22 ++
 rtl/display_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Bundle of display load/scan signals between a host and display_scan_ctrl.
// The host drives the master side; the scan controller is the slave.
interface display_scan_ctrl_if;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  hex_out;
  logic [7:0]  anode;
  logic        dp_out;

  modport master (
    output data_in, dp_in, blank_in, load,
    input  load_ack, hex_out, anode, dp_out
  );

  modport slave (
    input  data_in, dp_in, blank_in, load,
    output load_ack, hex_out, anode, dp_out
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with a dead-time guard
// between digits and frame-synchronous (tear-free) commit of new display data.
module display_scan_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int DEAD_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_scan_ctrl_if.slave   bus
);

  localparam int MAX_CYC = (TICK_DIV > DEAD_CYC) ? TICK_DIV : DEAD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [0:0] {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;

  logic [31:0]      disp_data_r;
  logic [7:0]       disp_dp_r;
  logic [7:0]       disp_blank_r;
  logic [31:0]      shadow_data_r;
  logic [7:0]       shadow_dp_r;
  logic [7:0]       shadow_blank_r;
  logic             pending_r;

  logic [3:0]       hex_r;
  logic [7:0]       anode_r;
  logic             dp_r;
  logic             ack_r;

  logic             drive_done_s;
  logic             dead_done_s;
  logic             commit_s;
  logic [3:0]       nibble_s;

  // Phase-end detection and frame-boundary commit qualifier.
  always_comb begin
    drive_done_s = (state_r == ST_DRIVE) && (cnt_r == CNT_W'(TICK_DIV - 1));
    dead_done_s  = (state_r == ST_DEAD)  && (cnt_r == CNT_W'(DEAD_CYC - 1));
    commit_s     = dead_done_s && (idx_r == 3'd7) && pending_r;
    nibble_s     = disp_data_r[{idx_r, 2'b00} +: 4];
  end

  // Scan FSM with registered digit outputs, display commit and pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_DEAD;
      cnt_r        <= {CNT_W{1'b0}};
      idx_r        <= 3'd7;
      anode_r      <= 8'hFF;
      dp_r         <= 1'b1;
      hex_r        <= 4'h0;
      ack_r        <= 1'b0;
      pending_r    <= 1'b0;
      disp_data_r  <= 32'h0000_0000;
      disp_dp_r    <= 8'h00;
      disp_blank_r <= 8'hFF;
    end else begin
      case (state_r)
        ST_DRIVE: begin
          // A blanked digit keeps its anode off but still tracks nibble/dp.
          anode_r <= disp_blank_r[idx_r] ? 8'hFF : ~(8'h01 << idx_r);
          hex_r   <= nibble_s;
          dp_r    <= ~disp_dp_r[idx_r];
          if (drive_done_s) begin
            state_r <= ST_DEAD;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          anode_r <= 8'hFF;
          dp_r    <= 1'b1;
          hex_r   <= hex_r;
          if (dead_done_s) begin
            state_r <= ST_DRIVE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= idx_r + 3'd1;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_DEAD;
          cnt_r   <= {CNT_W{1'b0}};
          anode_r <= 8'hFF;
          dp_r    <= 1'b1;
        end
      endcase

      // Commit takes the shadow as it stood before any same-cycle load.
      if (commit_s) begin
        disp_data_r  <= shadow_data_r;
        disp_dp_r    <= shadow_dp_r;
        disp_blank_r <= shadow_blank_r;
        ack_r        <= 1'b1;
      end else begin
        ack_r        <= 1'b0;
      end

      if (bus.load) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Shadow capture of host values on each load request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_data_r  <= 32'h0000_0000;
      shadow_dp_r    <= 8'h00;
      shadow_blank_r <= 8'hFF;
    end else if (bus.load) begin
      shadow_data_r  <= bus.data_in;
      shadow_dp_r    <= bus.dp_in;
      shadow_blank_r <= bus.blank_in;
    end else begin
      shadow_data_r  <= shadow_data_r;
      shadow_dp_r    <= shadow_dp_r;
      shadow_blank_r <= shadow_blank_r;
    end
  end

  assign bus.load_ack = ack_r;
  assign bus.hex_out  = hex_r;
  assign bus.anode    = anode_r;
  assign bus.dp_out   = dp_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl; expected outputs come
// from a time-based reference model (elapsed cycles -> slot -> digit).
`timescale 1ns/1ps
module tb_display_scan_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEAD_CYC = 1;
  localparam int SLOT     = TICK_DIV + DEAD_CYC;
  localparam int FRAME    = 8 * SLOT;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  display_scan_ctrl_if dut_if ();

  display_scan_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: cycles since reset release plus shadow/display copies.
  int unsigned m_n;
  logic        m_pend;
  logic [31:0] m_sh_data, m_ds_data;
  logic [7:0]  m_sh_dp, m_ds_dp, m_sh_blank, m_ds_blank;
  logic [7:0]  e_anode;
  logic [3:0]  e_hex;
  logic        e_dp;
  logic        e_ack;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {drive, idx} of the scan after n clock edges since reset release.
  function automatic logic [3:0] phase_of(input int unsigned n);
    int unsigned m;
    int unsigned slot;
    logic [2:0]  idx;
    if (n < DEAD_CYC) return {1'b0, 3'd7};
    m    = n - DEAD_CYC;
    slot = m / SLOT;
    idx  = 3'(slot % 8);
    return {((m % SLOT) < TICK_DIV) ? 1'b1 : 1'b0, idx};
  endfunction

  task automatic model_reset();
    m_n        = 0;
    m_pend     = 1'b0;
    m_sh_data  = 32'h0;
    m_ds_data  = 32'h0;
    m_sh_dp    = 8'h00;
    m_ds_dp    = 8'h00;
    m_sh_blank = 8'hFF;
    m_ds_blank = 8'hFF;
    e_anode    = 8'hFF;
    e_hex      = 4'h0;
    e_dp       = 1'b1;
    e_ack      = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] ph;
    logic [2:0] idx;
    ph  = phase_of(m_n);
    idx = ph[2:0];
    if (ph[3]) begin
      e_anode = m_ds_blank[idx] ? 8'hFF : ~(8'h01 << idx);
      e_hex   = 4'(m_ds_data >> (4 * idx));
      e_dp    = ~m_ds_dp[idx];
    end else begin
      e_anode = 8'hFF;
      e_dp    = 1'b1;
    end
    m_n++;
    if (m_n >= DEAD_CYC && ((m_n - DEAD_CYC) % FRAME) == 0 && m_pend) begin
      m_ds_data  = m_sh_data;
      m_ds_dp    = m_sh_dp;
      m_ds_blank = m_sh_blank;
      m_pend     = 1'b0;
      e_ack      = 1'b1;
    end else begin
      e_ack      = 1'b0;
    end
    if (dut_if.load) begin
      m_sh_data  = dut_if.data_in;
      m_sh_dp    = dut_if.dp_in;
      m_sh_blank = dut_if.blank_in;
      m_pend     = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    check_eq("anode",    dut_if.anode,    e_anode);
    check_eq("hex_out",  dut_if.hex_out,  e_hex);
    check_eq("dp_out",   dut_if.dp_out,   e_dp);
    check_eq("load_ack", dut_if.load_ack, e_ack);
  endtask

  // Per-cycle monitor: advance the model on each edge, compare 1ns later.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      compare_outputs();
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    @(negedge clk);
    dut_if.data_in  = d;
    dut_if.dp_in    = dp;
    dut_if.blank_in = bl;
    dut_if.load     = 1'b1;
    @(negedge clk);
    dut_if.load     = 1'b0;
  endtask

  task automatic apply_reset(input int hold);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_anode", dut_if.anode,    8'hFF);
    check_eq("rst_ack",   dut_if.load_ack, 1'b0);
    check_eq("rst_dp",    dut_if.dp_out,   1'b1);
    check_eq("rst_hex",   dut_if.hex_out,  4'h0);
    idle(hold);
    reset_n = 1'b1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    dut_if.data_in  = 32'h0;
    dut_if.dp_in    = 8'h00;
    dut_if.blank_in = 8'h00;
    dut_if.load     = 1'b0;
    model_reset();
    idle(3);
    reset_n = 1'b1;

    // Dark display after reset for two full frames.
    idle(2 * FRAME + 10);

    // Single load with one decimal point.
    do_load(32'h89AB_CDEF, 8'h04, 8'h00);
    idle(FRAME * 2 + 5);

    // Two loads within one frame: only the latest commits.
    do_load(32'h0000_0001, 8'h00, 8'h00);
    idle(7);
    do_load(32'h0000_0002, 8'h00, 8'h00);
    idle(FRAME * 2 + 3);

    // Upper four digits blanked.
    do_load($urandom, 8'($urandom), 8'hF0);
    idle(FRAME * 2);

    // Reset while digit 3 is being driven with a load pending.
    begin
      int  waited;
      logic [3:0] ph;
      waited = 0;
      ph = phase_of(m_n);
      while (!(ph[3] && ph[2:0] == 3'd3) && waited < 2 * FRAME) begin
        @(negedge clk);
        waited++;
        ph = phase_of(m_n);
      end
      check_eq("wait_digit3", (waited < 2 * FRAME) ? 1 : 0, 1);
      do_load(32'hDEAD_BEEF, 8'hFF, 8'h00);
      apply_reset(3);
      idle(2 * FRAME);
    end

    // Random loads at random spacing, including back-to-back and frame-edge hits.
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 60));
      do_load($urandom, 8'($urandom), 8'($urandom) & 8'($urandom));
      if (i == 25) begin
        idle($urandom_range(0, 30));
        apply_reset(2);
      end
    end
    idle(2 * FRAME + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
